// File: rtl/mul_pipe_unit_if.sv
// Request/response bundle for mul_pipe_unit.
// Handshake: a start is accepted in a cycle where start=1, flush=0 and busy=0 (idle); done pulses one
// cycle exactly LATENCY cycles later, and result then holds until the next accepted op completes.
interface mul_pipe_unit_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic                 is_signed;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 flush;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;

  modport master (
    output start, is_signed, a, b, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, is_signed, a, b, flush,
    output busy, done, result
  );
endinterface

// File: rtl/mul_pipe_unit.sv
// Fixed-latency signed/unsigned multiplier for the EX stage with start/busy/done handshake and flush.
// Operands are captured at accept; the product is written to result only in the done cycle.
module mul_pipe_unit #(
   parameter int WIDTH   = 32,
   parameter int LATENCY = 4
) (
   input  logic           clk,
   input  logic           rst,
   mul_pipe_unit_if.slave bus,
   output logic [1:0]     dbg_state
);

   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;

   logic [1:0]           state;
   logic [CW-1:0]        cnt;
   logic                 busy_r;
   logic                 done_r;
   logic [2*WIDTH-1:0]   result_r;
   logic [2*WIDTH-1:0]   op_a;
   logic [2*WIDTH-1:0]   op_b;
   logic [2*WIDTH-1:0]   ext_a;
   logic [2*WIDTH-1:0]   ext_b;
   logic [2*WIDTH-1:0]   mul_a;
   logic [2*WIDTH-1:0]   mul_b;
   logic [2*WIDTH-1:0]   product;
   logic                 accept;

   assign accept = bus.start && !bus.flush && (state == ST_IDLE);

   // Extending to 2*WIDTH makes the low half of an unsigned multiply correct for both modes.
   assign ext_a = bus.is_signed ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a} : {{WIDTH{1'b0}}, bus.a};
   assign ext_b = bus.is_signed ? {{WIDTH{bus.b[WIDTH-1]}}, bus.b} : {{WIDTH{1'b0}}, bus.b};

   // Single-cycle latency completes straight from the accepted operands.
   assign mul_a   = (LATENCY == 1) ? ext_a : op_a;
   assign mul_b   = (LATENCY == 1) ? ext_b : op_b;
   assign product = mul_a * mul_b;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         result_r <= '0;
         op_a     <= '0;
         op_b     <= '0;
      end else begin
         done_r <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  op_a <= ext_a;
                  op_b <= ext_b;
                  if (LATENCY == 1) begin
                     done_r   <= 1'b1;
                     result_r <= product;
                  end else begin
                     state  <= ST_RUN;
                     busy_r <= 1'b1;
                     cnt    <= CW'(1);
                  end
               end
            end
            ST_RUN: begin
               if (bus.flush) begin
                  state  <= ST_IDLE;
                  busy_r <= 1'b0;
                  cnt    <= '0;
               end else if (cnt == CW'(LATENCY - 1)) begin
                  done_r   <= 1'b1;
                  result_r <= product;
                  state    <= ST_IDLE;
                  busy_r   <= 1'b0;
                  cnt      <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               state  <= ST_IDLE;
               busy_r <= 1'b0;
               cnt    <= '0;
            end
         endcase
      end
   end

   assign bus.busy   = busy_r;
   assign bus.done   = done_r;
   assign bus.result = result_r;
   assign dbg_state  = state;

endmodule

// File: tb/tb_mul_pipe_unit.sv
// Randomized scoreboard bench for mul_pipe_unit: a 32-bit/latency-4 and an 8-bit/latency-1 instance.
// The driver predicts acceptance and completion cycles; a negedge monitor pops and compares.
module tb_mul_pipe_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mul_pipe_unit_if #(.WIDTH(32)) bus32 ();
  mul_pipe_unit_if #(.WIDTH(8))  bus8 ();
  logic [1:0] dbg32;
  logic [1:0] dbg8;

  mul_pipe_unit #(.WIDTH(32), .LATENCY(4)) u32 (
    .clk(clk), .rst(rst), .bus(bus32.slave), .dbg_state(dbg32)
  );
  mul_pipe_unit #(.WIDTH(8), .LATENCY(1)) u8 (
    .clk(clk), .rst(rst), .bus(bus8.slave), .dbg_state(dbg8)
  );

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [63:0] exp_res[2];

  // Timing model of the active instance
  int act      = 0;
  int acc_cyc  = -1;
  int busy_end = 0;
  int done_c   = 0;
  int free_c   = 0;
  int clr_cyc  = -1;
  bit chk_en   = 0;

  function automatic int lat_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic int width_of(input int d);
    return (d == 0) ? 32 : 8;
  endfunction

  // Plain integer product of the operands interpreted in the requested mode, truncated to 2*w bits.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input bit s, input int w);
    longint x, y, p, m;
    m = (w < 32) ? ((longint'(1) << w) - 1) : 64'h0000_0000_FFFF_FFFF;
    x = longint'({32'b0, a}) & m;
    y = longint'({32'b0, b}) & m;
    if (s && x[w-1]) x = x - (longint'(1) << w);
    if (s && y[w-1]) y = y - (longint'(1) << w);
    p = x * y;
    if (w < 32) p = p & ((longint'(1) << (2 * w)) - 1);
    return p;
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'h0000_0080;
      default: return $urandom;
    endcase
  endfunction

  task automatic drive(input int d, input bit st, input logic [31:0] a, input logic [31:0] b,
                       input bit s, input bit fl);
    int lat;
    @(posedge clk);
    #1;
    lat = lat_of(d);
    rst = 1'b1;
    bus32.start = (d == 0) && st;  bus32.flush = (d == 0) && fl;
    bus32.a = a;  bus32.b = b;  bus32.is_signed = s;
    bus8.start  = (d == 1) && st;  bus8.flush  = (d == 1) && fl;
    bus8.a = a[7:0];  bus8.b = b[7:0];  bus8.is_signed = s;
    act = d;
    if (fl) begin
      // Flush cancels only an op still strictly before its done cycle.
      if (acc_cyc < cyc && cyc < done_c) begin
        busy_end = cyc + 1;
        free_c   = cyc + 1;
        done_c   = 0;
        void'(exp_q.pop_back());
        void'(exp_cyc_q.pop_back());
      end
    end else if (st && cyc >= free_c) begin
      acc_cyc  = cyc;
      busy_end = cyc + lat;
      done_c   = cyc + lat;
      free_c   = cyc + lat;
      exp_q.push_back(ref_mul(a, b, s, width_of(d)));
      exp_cyc_q.push_back(cyc + lat);
    end
  endtask

  task automatic idle(input int d, input int n);
    for (int i = 0; i < n; i++) drive(d, 1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic rst_cycle();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus32.start = 1'b0;  bus32.flush = 1'b0;
    bus8.start  = 1'b0;  bus8.flush  = 1'b0;
    if (acc_cyc < cyc && cyc < done_c) begin
      busy_end = cyc + 1;
      done_c   = 0;
      void'(exp_q.pop_back());
      void'(exp_cyc_q.pop_back());
    end
    free_c  = cyc + 1;
    clr_cyc = cyc + 1;
  endtask

  task automatic check_dut(input int d, input logic done, input logic busy, input logic [63:0] res);
    logic exp_busy;
    logic [63:0] v;
    exp_busy = (d == act) && (acc_cyc < cyc) && (cyc < busy_end);
    total++;
    if (busy !== exp_busy) begin
      bad++;
      $display("FAIL busy[%0d] cyc=%0d got=%b want=%b", d, cyc, busy, exp_busy);
    end
    if (done === 1'b1) begin
      total++;
      if (d != act || exp_q.size() == 0 || exp_cyc_q[0] != cyc) begin
        bad++;
        $display("FAIL unexpected_done[%0d] cyc=%0d got=1 want=0", d, cyc);
      end else begin
        v = exp_q.pop_front();
        void'(exp_cyc_q.pop_front());
        exp_res[d] = v;
      end
    end else if (d == act && exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
      total++;
      bad++;
      $display("FAIL missing_done[%0d] cyc=%0d got=%b want=1", d, cyc, done);
      v = exp_q.pop_front();
      void'(exp_cyc_q.pop_front());
      exp_res[d] = v;
    end
    total++;
    if (res !== exp_res[d]) begin
      bad++;
      $display("FAIL result[%0d] cyc=%0d got=%h want=%h", d, cyc, res, exp_res[d]);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (cyc == clr_cyc) begin
        exp_res[0] = '0;
        exp_res[1] = '0;
      end
      check_dut(0, bus32.done, bus32.busy, bus32.result);
      check_dut(1, bus8.done, bus8.busy, {48'b0, bus8.result});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus32.start = 0; bus32.flush = 0; bus32.a = 0; bus32.b = 0; bus32.is_signed = 0;
    bus8.start  = 0; bus8.flush  = 0; bus8.a  = 0; bus8.b  = 0; bus8.is_signed  = 0;
    repeat (3) @(posedge clk);
    #1;
    exp_res[0] = '0;
    exp_res[1] = '0;
    chk_en = 1'b1;

    // Wide instance: directed corner cases
    drive(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);  idle(0, 6);
    drive(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);  idle(0, 14);
    drive(0, 1, 32'hFFFF_FFFF, 32'h0000_0002, 1, 0);  idle(0, 5);
    drive(0, 1, 32'h8000_0000, 32'h8000_0000, 0, 0);  idle(0, 5);
    drive(0, 1, 3, 5, 0, 0);  idle(0, 1);  drive(0, 0, 0, 0, 0, 1);  idle(0, 9);
    drive(0, 1, 7, 6, 0, 0);  idle(0, 5);
    drive(0, 1, 2, 3, 0, 0);  idle(0, 1);  drive(0, 1, 9, 9, 0, 0);  idle(0, 1);
    drive(0, 1, 4, 4, 0, 0);  idle(0, 6);
    drive(0, 1, 5, 5, 1, 0);  idle(0, 3);  drive(0, 1, 8, 8, 0, 1);  idle(0, 6);
    drive(0, 0, 0, 0, 0, 1);  idle(0, 2);
    drive(0, 1, 11, 13, 0, 0);  idle(0, 1);  rst_cycle();  idle(0, 8);

    for (int i = 0; i < 200; i++)
      drive(0, $urandom_range(0, 2) == 0, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)),
            $urandom_range(0, 9) == 0);
    idle(0, 8);

    // Narrow single-cycle instance
    drive(1, 1, 32'hFF, 32'hFF, 1, 0);  idle(1, 3);
    drive(1, 1, 32'hFF, 32'hFF, 0, 0);  idle(1, 3);
    drive(1, 1, 3, 5, 0, 0);  idle(1, 1);  drive(1, 0, 0, 0, 0, 1);  idle(1, 4);
    drive(1, 1, 3, 5, 0, 1);  idle(1, 2);
    drive(1, 1, 7, 6, 0, 0);  idle(1, 3);
    for (int i = 0; i < 150; i++)
      drive(1, $urandom_range(0, 1) == 0, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)),
            $urandom_range(0, 9) == 0);
    idle(1, 4);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_ops got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
